// File: rtl/capture_ctrl.sv
// capture_ctrl: sample-strobe generator and capture sequencer for a ring-buffer
// logic analyzer. Decimates probe_data by a programmable divider, counts pre- and
// post-trigger samples, and reports the ring index of the first post-trigger sample.
module capture_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              core_clk,
  input  logic              core_rst_n,
  input  logic              sample_en,
  input  logic [23:0]       sample_divider,
  input  logic [31:0]       sample_depth,
  input  logic [31:0]       pre_depth,
  input  logic              trig_hit,
  input  logic [DATA_W-1:0] probe_data,
  input  logic              wfifo_full,
  output logic              capture_valid,
  output logic [DATA_W-1:0] capture_data,
  output logic              capture_done,
  output logic [31:0]       sample_last_cnt,
  output logic [31:0]       trig_pos,
  output logic              overflow
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRETRIG   = 3'd1;
  localparam logic [2:0] S_WAIT_TRIG = 3'd2;
  localparam logic [2:0] S_POSTTRIG  = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              en_prev_q, en_prev_d;
  logic [23:0]       div_q, div_d;
  logic [23:0]       div_cnt_q, div_cnt_d;
  logic [31:0]       depth_q, depth_d;
  logic [31:0]       pre_q, pre_d;
  logic [31:0]       ring_idx_q, ring_idx_d;
  logic [31:0]       pre_cnt_q, pre_cnt_d;
  logic [31:0]       post_cnt_q, post_cnt_d;
  logic [31:0]       last_cnt_q, last_cnt_d;
  logic [31:0]       trig_pos_q, trig_pos_d;
  logic              capture_valid_q, capture_valid_d;
  logic [DATA_W-1:0] capture_data_q, capture_data_d;
  logic              capture_done_q, capture_done_d;
  logic              overflow_q, overflow_d;

  logic              en_rise;
  logic              active;
  logic              trig_now;
  logic              tick;
  logic [31:0]       depth_eff;
  logic [31:0]       pre_eff;
  logic [31:0]       post_need;
  logic [31:0]       ring_next;

  // Decode helpers: start edge, sample tick, clamped start parameters, ring wrap
  always_comb begin
    en_rise   = sample_en & ~en_prev_q;
    active    = (state_q == S_PRETRIG) || (state_q == S_WAIT_TRIG) || (state_q == S_POSTTRIG);
    depth_eff = (sample_depth == 32'd0) ? 32'd1 : sample_depth;
    pre_eff   = (pre_depth > depth_eff) ? depth_eff : pre_depth;
    post_need = depth_q - pre_q;
    trig_now  = (state_q == S_WAIT_TRIG) && sample_en && trig_hit;
    // A trigger that finds no post-trigger room ends the capture without a strobe;
    // an abort (sample_en low) also suppresses the tick.
    tick      = active && sample_en && (div_cnt_q == 24'd0) &&
                !(trig_now && (post_need == 32'd0));
    ring_next = (ring_idx_q == last_cnt_q) ? 32'd0 : ring_idx_q + 32'd1;
  end

  // Next-state logic for the FSM, counters and output registers
  always_comb begin
    state_d         = state_q;
    en_prev_d       = sample_en;
    div_d           = div_q;
    div_cnt_d       = div_cnt_q;
    depth_d         = depth_q;
    pre_d           = pre_q;
    ring_idx_d      = ring_idx_q;
    pre_cnt_d       = pre_cnt_q;
    post_cnt_d      = post_cnt_q;
    last_cnt_d      = last_cnt_q;
    trig_pos_d      = trig_pos_q;
    capture_valid_d = tick;
    capture_data_d  = tick ? probe_data : capture_data_q;
    overflow_d      = overflow_q | (capture_valid_q & wfifo_full);

    if (active) begin
      div_cnt_d = (div_cnt_q == 24'd0) ? div_q : div_cnt_q - 24'd1;
    end
    if (tick) begin
      ring_idx_d = ring_next;
    end

    case (state_q)
      S_IDLE: begin
        if (en_rise) begin
          depth_d    = depth_eff;
          pre_d      = pre_eff;
          div_d      = sample_divider;
          last_cnt_d = depth_eff - 32'd1;
          ring_idx_d = 32'd0;
          pre_cnt_d  = 32'd0;
          post_cnt_d = 32'd0;
          overflow_d = 1'b0;
          state_d    = (pre_eff != 32'd0) ? S_PRETRIG : S_WAIT_TRIG;
        end
      end
      S_PRETRIG: begin
        if (!sample_en) begin
          state_d = S_IDLE;
        end else if (tick) begin
          pre_cnt_d = pre_cnt_q + 32'd1;
          if (pre_cnt_q + 32'd1 == pre_q) begin
            state_d = S_WAIT_TRIG;
          end
        end
      end
      S_WAIT_TRIG: begin
        if (!sample_en) begin
          state_d = S_IDLE;
        end else if (trig_hit) begin
          // The next strobed sample (or the coincident one) sits at the current index.
          trig_pos_d = ring_idx_q;
          if (post_need == 32'd0) begin
            state_d = S_DONE;
          end else if (tick) begin
            post_cnt_d = post_need - 32'd1;
            state_d    = (post_need == 32'd1) ? S_DONE : S_POSTTRIG;
          end else begin
            post_cnt_d = post_need;
            state_d    = S_POSTTRIG;
          end
        end
      end
      S_POSTTRIG: begin
        if (!sample_en) begin
          state_d = S_IDLE;
        end else if (tick) begin
          post_cnt_d = post_cnt_q - 32'd1;
          if (post_cnt_q == 32'd1) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!sample_en) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The divider counter idles at zero so the first active cycle always ticks.
    if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
      div_cnt_d = 24'd0;
    end
    capture_done_d = (state_d == S_DONE);
  end

  // State registers; en_prev resets high so a level held through reset cannot start a capture
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q         <= S_IDLE;
      en_prev_q       <= 1'b1;
      div_q           <= 24'd0;
      div_cnt_q       <= 24'd0;
      depth_q         <= 32'd0;
      pre_q           <= 32'd0;
      ring_idx_q      <= 32'd0;
      pre_cnt_q       <= 32'd0;
      post_cnt_q      <= 32'd0;
      last_cnt_q      <= 32'd0;
      trig_pos_q      <= 32'd0;
      capture_valid_q <= 1'b0;
      capture_data_q  <= '0;
      capture_done_q  <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      en_prev_q       <= en_prev_d;
      div_q           <= div_d;
      div_cnt_q       <= div_cnt_d;
      depth_q         <= depth_d;
      pre_q           <= pre_d;
      ring_idx_q      <= ring_idx_d;
      pre_cnt_q       <= pre_cnt_d;
      post_cnt_q      <= post_cnt_d;
      last_cnt_q      <= last_cnt_d;
      trig_pos_q      <= trig_pos_d;
      capture_valid_q <= capture_valid_d;
      capture_data_q  <= capture_data_d;
      capture_done_q  <= capture_done_d;
      overflow_q      <= overflow_d;
    end
  end

  assign capture_valid   = capture_valid_q;
  assign capture_data    = capture_data_q;
  assign capture_done    = capture_done_q;
  assign sample_last_cnt = last_cnt_q;
  assign trig_pos        = trig_pos_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed scenarios with a strobe scoreboard. Stimulus pushes the
// expected (data, cycle) of every strobe; the monitor pops on each capture_valid.
module tb_capture_ctrl;

  logic        core_clk = 1'b0;
  logic        core_rst_n;
  logic        sample_en;
  logic [23:0] sample_divider;
  logic [31:0] sample_depth;
  logic [31:0] pre_depth;
  logic        trig_hit;
  logic [15:0] probe_data;
  logic        wfifo_full;
  logic        capture_valid;
  logic [15:0] capture_data;
  logic        capture_done;
  logic [31:0] sample_last_cnt;
  logic [31:0] trig_pos;
  logic        overflow;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] pat = 16'h1234;

  capture_ctrl #(.DATA_W(16)) dut (
    .core_clk        (core_clk),
    .core_rst_n      (core_rst_n),
    .sample_en       (sample_en),
    .sample_divider  (sample_divider),
    .sample_depth    (sample_depth),
    .pre_depth       (pre_depth),
    .trig_hit        (trig_hit),
    .probe_data      (probe_data),
    .wfifo_full      (wfifo_full),
    .capture_valid   (capture_valid),
    .capture_data    (capture_data),
    .capture_done    (capture_done),
    .sample_last_cnt (sample_last_cnt),
    .trig_pos        (trig_pos),
    .overflow        (overflow)
  );

  always #5 core_clk = ~core_clk;

  always @(posedge core_clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the next queued expectation in data and cycle
  always @(negedge core_clk) begin
    if (capture_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected: got strobe at cyc %0d data %04h, required none", cyc, capture_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (capture_data !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL strobe: got data %04h at cyc %0d, required data %04h at cyc %0d",
                   capture_data, cyc, e.data, e.cyc);
        end else begin
          $display("strobe cyc %0d data %04h ok", cyc, capture_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, capture_valid}, 32'd0);
    check({tag, "_data"}, {16'd0, capture_data}, 32'd0);
    check({tag, "_done"}, {31'd0, capture_done}, 32'd0);
    check({tag, "_last"}, sample_last_cnt, 32'd0);
    check({tag, "_trigpos"}, trig_pos, 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  // One clock of stimulus; tk says this edge is a tick, so the sampled probe value is expected next cycle
  task automatic step(input logic tk, input logic trg, input logic full);
    probe_data = pat;
    pat        = pat + 16'h0F1D;
    trig_hit   = trg;
    wfifo_full = full;
    if (tk) exp_q.push_back('{probe_data, cyc + 1});
    @(posedge core_clk);
    #1;
    trig_hit   = 1'b0;
    wfifo_full = 1'b0;
  endtask

  task automatic start(input logic [31:0] depth, input logic [31:0] pre, input logic [23:0] div);
    sample_depth   = depth;
    pre_depth      = pre;
    sample_divider = div;
    sample_en      = 1'b1;
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    core_rst_n     = 1'b1;
    sample_en      = 1'b0;
    sample_divider = 24'd0;
    sample_depth   = 32'd0;
    pre_depth      = 32'd0;
    trig_hit       = 1'b0;
    probe_data     = 16'd0;
    wfifo_full     = 1'b0;
    #2 core_rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge core_clk);
    #1 core_rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // depth 8, pre 3, divider 0, trigger 5 cycles into WAIT_TRIG: 3 pre + 5 post strobes
    start(32'd8, 32'd3, 24'd0);
    for (int k = 0; k <= 14; k++) step(k <= 12, k == 8, 1'b0);
    check("s1_done", {31'd0, capture_done}, 32'd1);
    check("s1_last", sample_last_cnt, 32'd7);
    check("s1_trigpos", trig_pos, 32'd0);
    sample_en = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("s1_done_fall", {31'd0, capture_done}, 32'd0);

    // divider 3: one strobe every 4 cycles, trigger between ticks
    start(32'd5, 32'd0, 24'd3);
    for (int k = 0; k <= 34; k++) step((k % 4 == 0) && (k <= 32), k == 13, 1'b0);
    check("s2_done", {31'd0, capture_done}, 32'd1);
    check("s2_last", sample_last_cnt, 32'd4);
    check("s2_trigpos", trig_pos, 32'd4);
    sample_en = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // pre_depth 20 clamped to depth 10; trigger in PRETRIG ignored; done on trigger
    start(32'd10, 32'd20, 24'd3);
    for (int k = 0; k <= 39; k++) step((k % 4 == 0) && (k <= 36), (k == 5) || (k == 37), 1'b0);
    check("s3_done", {31'd0, capture_done}, 32'd1);
    check("s3_last", sample_last_cnt, 32'd9);
    check("s3_trigpos", trig_pos, 32'd0);
    sample_en = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // abort in WAIT_TRIG: done never rises
    start(32'd4, 32'd1, 24'd0);
    for (int k = 0; k <= 2; k++) begin
      step(1'b1, 1'b0, 1'b0);
      check("s4_done_low", {31'd0, capture_done}, 32'd0);
    end
    sample_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check("s4_abort_done", {31'd0, capture_done}, 32'd0);
    end

    // restart after abort, with wfifo_full during the first strobe
    start(32'd2, 32'd0, 24'd1);
    for (int k = 0; k <= 6; k++) step((k % 2 == 0) && (k <= 4), k == 1, k == 1);
    check("s5_done", {31'd0, capture_done}, 32'd1);
    check("s5_trigpos", trig_pos, 32'd1);
    check("s5_last", sample_last_cnt, 32'd1);
    check("s5_ovf", {31'd0, overflow}, 32'd1);
    sample_en = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("s5_ovf_idle", {31'd0, overflow}, 32'd1);

    // next start clears overflow; reset pulsed during POSTTRIG
    start(32'd4, 32'd0, 24'd0);
    check("s6_ovf_clr", {31'd0, overflow}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("s6_trigpos", trig_pos, 32'd1);
    #6 core_rst_n = 1'b0;
    #1 check_zero("midreset");
    @(posedge core_clk);
    #1 core_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check("s6_no_restart", {31'd0, capture_done}, 32'd0);
    end
    sample_en = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // depth 0 treated as 1; trigger coincident with a tick
    start(32'd0, 32'd0, 24'd0);
    for (int k = 0; k <= 3; k++) step(k <= 1, k == 1, 1'b0);
    check("s7_done", {31'd0, capture_done}, 32'd1);
    check("s7_last", sample_last_cnt, 32'd0);
    sample_en = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    check("leftover_expected", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
